// File: rtl/store_write_buffer_pkg.sv
// Shared encodings for the store write buffer: access sizes and byte-lane enables.
// Used by the lane encoder and by the buffer top level.
package store_write_buffer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_B1  = 4'b0010;
    localparam logic [3:0] BE_B2  = 4'b0100;
    localparam logic [3:0] BE_B3  = 4'b1000;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // Single-byte lane enable for a byte offset within the word.
    function automatic logic [3:0] byte_lane(input logic [1:0] ofs);
        logic [3:0] be;
        be = BE_B0;
        case (ofs)
            2'd0: be = BE_B0;
            2'd1: be = BE_B1;
            2'd2: be = BE_B2;
            2'd3: be = BE_B3;
            default: be = BE_B0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_write_buffer_lane.sv
// Store lane encoder: replicates store data across lanes and derives byte enables.
// Latency: purely combinational. Backpressure: none, no state.
// Legality: halfwords need addr[0]=0, words need addr[1:0]=00, size 11 never legal.
module store_lane_encoder
    import store_write_buffer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        legal
);

    always_comb begin
        byte_en   = '0;
        lane_data = '0;
        legal     = 1'b0;
        case (size)
            SZ_BYTE: begin
                legal     = 1'b1;
                lane_data = {4{data[7:0]}};
                byte_en   = byte_lane(addr_lo);
            end
            SZ_HALF: begin
                legal     = ~addr_lo[0];
                lane_data = {2{data[15:0]}};
                byte_en   = addr_lo[1] ? BE_HHI : BE_HLO;
            end
            SZ_WORD: begin
                legal     = (addr_lo == 2'b00);
                lane_data = data;
                byte_en   = BE_W;
            end
            default: begin
                // Reserved size: left at defaults, rejected by legal=0.
                legal     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-encodes MEM-stage stores and queues them toward data memory.
// Latency: an accepted store is visible on mem_write the cycle after the accepting edge.
// Backpressure: store_ready drops when full (from count only); head holds until mem_ack.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          store_valid,
    input  logic [1:0]    store_size,
    input  logic [AW-1:0] store_addr,
    input  logic [31:0]   store_data,
    output logic          store_ready,
    output logic          align_err,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_write_data,
    output logic [3:0]    mem_byte_en,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } entry_t;

    entry_t        entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [3:0]    enc_be;
    logic [31:0]   enc_data;
    logic          enc_legal;
    logic          accept;
    logic          enq;
    logic          deq;

    store_lane_encoder u_enc (
        .size      (store_size),
        .addr_lo   (store_addr[1:0]),
        .data      (store_data),
        .byte_en   (enc_be),
        .lane_data (enc_data),
        .legal     (enc_legal)
    );

    assign store_ready = (count != FULL);
    assign empty       = (count == '0);
    assign mem_write   = ~empty;

    assign accept = store_valid & store_ready;
    assign enq    = accept & enc_legal;
    assign deq    = mem_write & mem_ack;

    // Head is read straight from storage; storage is cleared on reset so idle outputs read 0.
    assign mem_addr       = entries[rd_ptr].addr;
    assign mem_write_data = entries[rd_ptr].data;
    assign mem_byte_en    = entries[rd_ptr].be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            align_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            align_err <= accept & ~enc_legal;
            if (enq) begin
                entries[wr_ptr] <= '{addr: {store_addr[AW-1:2], 2'b00},
                                     data: enc_data,
                                     be:   enc_be};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized and directed bench for store_write_buffer with a queue-based reference model.
// A negedge monitor tracks occupancy, error pulses and head contents against the model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          store_valid = 1'b0;
    logic [1:0]    store_size = 2'b00;
    logic [AW-1:0] store_addr = '0;
    logic [31:0]   store_data = '0;
    logic          store_ready;
    logic          align_err;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic [3:0]    mem_byte_en;
    logic          mem_ack = 1'b0;
    logic          empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t q[$];
    bit   exp_err = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .store_valid    (store_valid),
        .store_size     (store_size),
        .store_addr     (store_addr),
        .store_data     (store_data),
        .store_ready    (store_ready),
        .align_err      (align_err),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_byte_en    (mem_byte_en),
        .mem_ack        (mem_ack),
        .empty          (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: legality and memory image of one store, from plain arithmetic.
    function automatic bit model(input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, output exp_t e);
        int ofs;
        ofs    = int'(a % 4);
        e.addr = a - 32'(ofs);
        e.data = 0;
        e.be   = 0;
        case (sz)
            2'd0: begin
                e.data = (d & 32'hFF) * 32'h0101_0101;
                e.be   = 4'(1 << ofs);
                return 1'b1;
            end
            2'd1: begin
                e.data = (d & 32'hFFFF) * 32'h0001_0001;
                e.be   = (ofs >= 2) ? 4'd12 : 4'd3;
                return (ofs % 2) == 0;
            end
            2'd2: begin
                e.data = d;
                e.be   = 4'd15;
                return ofs == 0;
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   full_before;
        if (!rst_n) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            check("store_ready", store_ready, q.size() != DEPTH);
            check("empty", empty, q.size() == 0);
            check("mem_write", mem_write, q.size() != 0);
            check("align_err", align_err, exp_err);
            if (q.size() != 0) begin
                check("head_addr", mem_addr, q[0].addr);
                check("head_data", mem_write_data, q[0].data);
                check("head_be", mem_byte_en, q[0].be);
            end
            full_before = (q.size() == DEPTH);
            if (mem_ack && q.size() != 0) void'(q.pop_front());
            exp_err = 1'b0;
            if (store_valid && !full_before) begin
                if (model(store_size, store_addr, store_data, e)) q.push_back(e);
                else exp_err = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        store_valid = v;
        store_size  = sz;
        store_addr  = a;
        store_data  = d;
    endtask

    task automatic legal_random_store();
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 2));
        a  = $urandom;
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        offer(1'b1, sz, a, $urandom);
    endtask

    initial begin
        int n;
        #2;
        check("rst_ready", store_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_mem_write", mem_write, 0);
        check("rst_align_err", align_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_byte_en, 0);
        #6 rst_n = 1'b1;
        tick();

        // Byte store with ack tied high.
        mem_ack = 1'b1;
        offer(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5);
        tick();
        offer(1'b0, 2'd0, 0, 0);
        check("byte_mem_write", mem_write, 1);
        check("byte_addr", mem_addr, 32'h0000_1000);
        check("byte_data", mem_write_data, 32'hA5A5_A5A5);
        check("byte_be", mem_byte_en, 4'b1000);
        tick();
        check("byte_drained", empty, 1);

        // Halfword upper lane, then misaligned halfword.
        offer(1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF);
        tick();
        check("half_data", mem_write_data, 32'hBEEF_BEEF);
        check("half_be", mem_byte_en, 4'b1100);
        offer(1'b1, 2'd1, 32'h0000_2001, 32'h1234_BEEF);
        tick();
        offer(1'b0, 2'd0, 0, 0);
        check("misalign_err", align_err, 1);
        check("misalign_no_write", mem_write, 0);
        tick();
        check("misalign_err_pulse", align_err, 0);

        // Fill to full with ack held low, hold the fifth, then drain in order.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 2'd2, 32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1));
            tick();
        end
        check("full_ready_low", store_ready, 0);
        offer(1'b1, 2'd2, 32'h110, 32'h55);
        repeat (3) tick();
        check("full_head_hold", mem_write_data, 32'h11);
        mem_ack = 1'b1;
        tick();
        tick();
        offer(1'b0, 2'd0, 0, 0);
        repeat (6) tick();
        check("full_drained", empty, 1);

        // Continuous enqueue with continuous ack: pointer wrap.
        for (int i = 0; i < 12; i++) begin
            legal_random_store();
            tick();
        end
        offer(1'b0, 2'd0, 0, 0);
        repeat (2) tick();

        // Asynchronous reset with three entries pending.
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 2'd2, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
            tick();
        end
        offer(1'b0, 2'd0, 0, 0);
        check("pre_rst_write", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_write", mem_write, 0);
        check("arst_empty", empty, 1);
        check("arst_ready", store_ready, 1);
        check("arst_addr", mem_addr, 0);
        check("arst_data", mem_write_data, 0);
        check("arst_be", mem_byte_en, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_empty", empty, 1);
        check("post_rst_no_write", mem_write, 0);

        // Reserved size, then a normal word store.
        offer(1'b1, 2'd3, 32'h300, 32'hDEAD_BEEF);
        tick();
        check("rsvd_err", align_err, 1);
        check("rsvd_not_queued", empty, 1);
        offer(1'b1, 2'd2, 32'h304, 32'hCAFE_F00D);
        tick();
        offer(1'b0, 2'd0, 0, 0);
        check("word_be", mem_byte_en, 4'b1111);
        check("word_data", mem_write_data, 32'hCAFE_F00D);
        check("word_no_err", align_err, 0);
        mem_ack = 1'b1;
        repeat (2) tick();

        // Random traffic, including misaligned and reserved sizes.
        for (int i = 0; i < 2000; i++) begin
            offer($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, $urandom);
            mem_ack = $urandom_range(0, 9) < 6;
            tick();
        end
        offer(1'b0, 2'd0, 0, 0);
        mem_ack = 1'b1;
        n = 0;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        check("final_drain", empty, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart to the load-path sign-extension logic.
- Takes a 32-bit register value plus an access size (byte, halfword or word) from the MEM stage.
- Narrows it into lane-replicated write data with byte enables, and queues it in a small FIFO.
- Drains the FIFO to data memory over a write/acknowledge handshake, so the pipeline does not stall on slow memory writes.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- AW, 32, address width.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- StoreValid  input  1  MEM stage presents a store this cycle.
- StoreSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- StoreAddr  input  AW  byte address of the store.
- StoreData  input  32  register value; low bits are significant for byte and halfword.
- StoreReady  output  1  buffer can accept a store this cycle.
- AlignErr  output  1  one-cycle pulse: an offered store was misaligned or reserved-size and was dropped.
- MemWrite  output  1  head entry valid toward memory.
- MemAddr  output  AW  word-aligned address, {StoreAddr[AW-1:2], 2'b00}.
- MemWriteData  output  32  lane-replicated data.
- MemByteEn  output  4  byte-lane enables.
- MemAck  input  1  memory accepted the head entry this cycle.
- Empty  output  1  no entries queued.

Behaviour:
- Reset (Rst=0, asynchronous): pointers and count go to 0; all entries are discarded, including ones mid-drain.
  - AlignErr=0, MemWrite=0, Empty=1, StoreReady=1.
  - MemAddr, MemWriteData and MemByteEn go to 0.
- StoreReady = (count != DEPTH). It is combinational from count only and never depends on MemAck, so a full buffer does not bypass.
- Accept condition: StoreValid & StoreReady at a rising edge.
- Legality check on an accepted store:
  - Byte: always legal.
  - Halfword: legal if StoreAddr[0]=0.
  - Word: legal if StoreAddr[1:0]=00.
  - Size 11: always illegal.
  - Illegal store: not enqueued; AlignErr is registered high for exactly the next cycle.
  - An offer while full raises no AlignErr; the producer must hold the store.
- Lane encoding, written into the entry at enqueue:
  - Byte: data = {4{d[7:0]}}; ByteEn = 0001 shifted left by addr[1:0].
  - Halfword: data = {2{d[15:0]}}; ByteEn = 0011 if addr[1]=0, else 1100.
  - Word: data = d; ByteEn = 1111.
- Drain side:
  - MemWrite = !Empty. MemAddr, MemWriteData and MemByteEn show the head entry directly from storage.
  - Dequeue on MemWrite & MemAck. MemAck while empty is ignored.
  - Head outputs hold stable while MemWrite=1 and MemAck=0.
- Latency: a store accepted at edge N into an empty buffer drives MemWrite=1 from edge N (visible in cycle N+1). There is no combinational pass-through from StoreValid to MemWrite.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When count=1 this is legal: the head is retired and the new entry becomes the head.
- Pointer widths are log2(DEPTH) and wrap naturally. Count is log2(DEPTH)+1 bits and saturates logically at DEPTH (guarded by StoreReady) and at 0 (guarded by Empty).
- Ordering: strict FIFO, with no write merging or coalescing.

Decomposition:
- Shared package: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11; byte-enable constants BE_B0..BE_B3, BE_HLO=4'b0011, BE_HHI=4'b1100, BE_W=4'b1111.
- One sub-module: store_lane_encoder.
  - Purely combinational: size, addr[1:0] and data in; ByteEn, lane data and legal out.
  - Instantiated once on the enqueue path. The FIFO and handshake stay in store_write_buffer.

Test Plan:
- Reset with MemAck tied 1, then byte store, StoreAddr=0x1003, StoreData=0x000000A5 → next cycle MemWrite=1, MemAddr=0x1000, MemWriteData=0xA5A5A5A5, MemByteEn=1000; Empty returns to 1 after one ack.
- Halfword at 0x2002, data 0x1234BEEF → MemWriteData=0xBEEFBEEF, MemByteEn=1100. Halfword at 0x2001 → AlignErr pulses one cycle, MemWrite stays 0.
- MemAck held 0; offer 5 word stores 0x11..0x55 back-to-back → StoreReady drops after the 4th accept, 5th held. Then MemAck=1 → writes emerge in order 0x11, 0x22, 0x33, 0x44, then 0x55 after it is accepted.
- DEPTH=4 with continuous enqueue plus MemAck=1 for 12 cycles → pointer wrap exercised, no loss or duplication; the data sequence matches a scoreboard.
- 3 entries queued with MemWrite=1 and MemAck=0; pull Rst low mid-cycle → outputs clear immediately (asynchronously); after release Empty=1 and no stale write appears.
- Size 11 at an aligned address → AlignErr pulse, count unchanged. A word store on the next cycle is accepted normally with MemByteEn=1111.
